// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset/NOP constants, fetch state encoding and the
// primary opcodes decoded in ID.
package cpu_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry instruction register used by the fetch stage to park an
// instruction that returned while the pipeline was stalled.
module if_hold_buf
  import cpu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o
);

  logic [W-1:0] data_r;
  logic         full_r;

  // Entry storage; clear wins over load so a redirect always empties it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r <= {W{1'b0}};
      full_r <= 1'b0;
    end else if (clear_i) begin
      data_r <= data_r;
      full_r <= 1'b0;
    end else if (load_i) begin
      data_r <= data_i;
      full_r <= 1'b1;
    end else begin
      data_r <= data_r;
      full_r <= full_r;
    end
  end

  assign data_o = data_r;
  assign full_o = full_r;

endmodule

// File: rtl/if_id_fetch_stage.sv
// Fetch stage with PC, imem request and the IF/ID pipeline register.
// Optional stall/flush counters are enabled by defining IF_PERF_CNT_EN.
module if_id_fetch_stage
  import cpu_pkg::*;
#(
  parameter int                    PC_WIDTH    = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = cpu_pkg::RESET_PC[PC_WIDTH-1:0],
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = cpu_pkg::NOP_INSTR[INSTR_WIDTH-1:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_data_i,
  input  logic                   stall_ctrl_i,
  input  logic                   branch_taken_i,
  input  logic [PC_WIDTH-1:0]    branch_target_i,
  output logic                   imem_req_o,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  input  logic                   imem_rdy_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]            if_stall_cycles_o,
  output logic [31:0]            if_flush_cnt_o,
`endif
  output logic                   if_id_valid_o,
  output logic [PC_WIDTH-1:0]    if_id_pc_o,
  output logic [PC_WIDTH-1:0]    if_id_pc4_o,
  output logic [INSTR_WIDTH-1:0] if_id_instr_o
);

  fetch_state_e           state_r;
  logic [PC_WIDTH-1:0]    pc_r;
  logic                   valid_r;
  logic [PC_WIDTH-1:0]    id_pc_r;
  logic [PC_WIDTH-1:0]    id_pc4_r;
  logic [INSTR_WIDTH-1:0] id_instr_r;

  logic                   stall_s;
  logic                   avail_s;
  logic [INSTR_WIDTH-1:0] instr_s;
  logic                   hold_load_s;
  logic                   hold_clear_s;
  logic [INSTR_WIDTH-1:0] hold_data_s;
  logic                   hold_full_s;
  logic [PC_WIDTH-1:0]    pc4_s;

  // Hazard/availability decode for the current cycle.
  always_comb begin
    stall_s      = stall_data_i | stall_ctrl_i;
    pc4_s        = pc_r + PC_WIDTH'(4);
    hold_load_s  = stall_s & (state_r == S_FETCH) & imem_rdy_i;
    // Leaving S_HOLD (consumed or flushed) or any accepted redirect empties it.
    hold_clear_s = ~stall_s & (branch_taken_i | (state_r == S_HOLD));
    case (state_r)
      S_FETCH: begin
        avail_s = imem_rdy_i;
        instr_s = imem_rdata_i;
      end
      S_HOLD: begin
        avail_s = hold_full_s;
        instr_s = hold_data_s;
      end
      default: begin
        avail_s = 1'b0;
        instr_s = NOP_INSTR;
      end
    endcase
  end

  if_hold_buf #(.W(INSTR_WIDTH)) u_hold_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (hold_load_s),
    .clear_i (hold_clear_s),
    .data_i  (imem_rdata_i),
    .data_o  (hold_data_s),
    .full_o  (hold_full_s)
  );

  // PC, fetch state and IF/ID register, in stall > redirect > fetch priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= S_FETCH;
      pc_r       <= RESET_PC;
      valid_r    <= 1'b0;
      id_pc_r    <= {PC_WIDTH{1'b0}};
      id_pc4_r   <= {PC_WIDTH{1'b0}};
      id_instr_r <= NOP_INSTR;
    end else if (stall_s) begin
      if (hold_load_s) begin
        state_r <= S_HOLD;
      end else begin
        state_r <= state_r;
      end
    end else if (branch_taken_i) begin
      state_r    <= S_FETCH;
      pc_r       <= branch_target_i;
      valid_r    <= 1'b0;
      id_instr_r <= NOP_INSTR;
    end else if (avail_s) begin
      state_r    <= S_FETCH;
      pc_r       <= pc4_s;
      valid_r    <= 1'b1;
      id_pc_r    <= pc_r;
      id_pc4_r   <= pc4_s;
      id_instr_r <= instr_s;
    end else begin
      state_r    <= S_FETCH;
      valid_r    <= 1'b0;
      id_instr_r <= NOP_INSTR;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Saturating stall-cycle and accepted-redirect counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'h0000_0000;
      flush_cnt_r <= 32'h0000_0000;
    end else begin
      if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (!stall_s && branch_taken_i && (flush_cnt_r != 32'hFFFF_FFFF)) begin
        flush_cnt_r <= flush_cnt_r + 32'h0000_0001;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign if_stall_cycles_o = stall_cnt_r;
  assign if_flush_cnt_o    = flush_cnt_r;
`endif

  assign imem_req_o    = rst_n & (state_r == S_FETCH);
  assign imem_addr_o   = pc_r;
  assign if_id_valid_o = valid_r;
  assign if_id_pc_o    = id_pc_r;
  assign if_id_pc4_o   = id_pc4_r;
  assign if_id_instr_o = id_instr_r;

endmodule
